// File: rtl/system_acl_iface_pio_in_pkg.sv
// Shared register map and reset-value rules for the debounced PIO input block.
// Pure constants/functions: no logic, no latency, no flow control.
package acl_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_DB_LIMIT = 3'd5;
    localparam logic [2:0] ADDR_PENDING  = 3'd6;

    // Every implemented channel comes out of reset with falling-edge capture enabled.
    function automatic logic [31:0] fall_en_reset(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/system_acl_iface_pio_in_if.sv
// Register-slave bus: select/strobe/address/data in, registered read data out.
// Reads return one cycle after the address is presented; the slave never stalls.
interface system_acl_iface_pio_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/system_acl_iface_pio_in_debounce.sv
// One channel: 2-flop synchroniser then debounce (PIO_DEBOUNCE_EN) or a plain retiming flop.
// Stable follows the synchronised input after DB_LIMIT+1 agreeing cycles; no backpressure.
module acl_pio_debounce #(
    parameter int DB_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_raw,
`ifdef PIO_DEBOUNCE_EN
    input  logic [DB_W-1:0] db_limit,
`endif
    output logic            stable
);

    logic [1:0] sync_q;
    logic       sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], in_raw};
    end

    assign sync = sync_q[1];

`ifdef PIO_DEBOUNCE_EN
    logic [DB_W-1:0] cnt;

    // Counter holds at all-ones rather than wrapping back below the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt >= db_limit) begin
            stable <= sync;
            cnt    <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    localparam int unused_db_w = DB_W;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable <= 1'b0;
        else          stable <= sync;
    end
`endif

endmodule

// File: rtl/system_acl_iface_pio_in.sv
// Debounced PIO input with edge capture and level irq; optional debounce via PIO_DEBOUNCE_EN.
// readdata registered every cycle (1-cycle read latency); writes always accepted, no backpressure.
module system_acl_iface_pio_in
    import acl_pio_pkg::*;
#(
    parameter int          WIDTH  = 2,
    parameter int          DB_W   = 16,
    parameter logic [15:0] DB_RST = 16'd0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    system_acl_iface_pio_in_if.slave   bus,
    input  logic [WIDTH-1:0]           in_port,
    output logic                       irq
);

    localparam logic [WIDTH-1:0] FALL_RST = WIDTH'(fall_en_reset(WIDTH));

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] stable_prev;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign unused_wd = ^bus.writedata;

`ifdef PIO_DEBOUNCE_EN
    logic [DB_W-1:0] db_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            db_limit <= DB_RST[DB_W-1:0];
        else if (wr_en && bus.address == ADDR_DB_LIMIT)
            db_limit <= bus.writedata[DB_W-1:0];
    end
`else
    localparam int unused_db_rst = int'(DB_RST);
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        acl_pio_debounce #(.DB_W(DB_W)) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_raw   (in_port[i]),
`ifdef PIO_DEBOUNCE_EN
            .db_limit (db_limit),
`endif
            .stable   (data[i])
        );
    end

    // stable_prev resets to 0 alongside stable, so only a genuine 0->1 counts as a rise.
    assign edge_det = (data & ~stable_prev & rise_en) | (~data & stable_prev & fall_en);
    assign cap_clr  = (wr_en && bus.address == ADDR_EDGE_CAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign irq      = |(edge_cap & irq_mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_prev <= '0;
            rise_en     <= '0;
            irq_mask    <= '0;
            edge_cap    <= '0;
            fall_en     <= FALL_RST;
        end else begin
            stable_prev <= data;
            // Set is OR-ed in after the clear so a coincident edge wins.
            edge_cap    <= (edge_cap & ~cap_clr) | edge_det;
            if (wr_en) begin
                case (bus.address)
                    ADDR_RISE_EN:  rise_en  <= bus.writedata[WIDTH-1:0];
                    ADDR_IRQ_MASK: irq_mask <= bus.writedata[WIDTH-1:0];
                    ADDR_FALL_EN:  fall_en  <= bus.writedata[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:     rd_next = 32'(data);
            ADDR_RISE_EN:  rd_next = 32'(rise_en);
            ADDR_IRQ_MASK: rd_next = 32'(irq_mask);
            ADDR_EDGE_CAP: rd_next = 32'(edge_cap);
            ADDR_FALL_EN:  rd_next = 32'(fall_en);
`ifdef PIO_DEBOUNCE_EN
            ADDR_DB_LIMIT: rd_next = 32'(db_limit);
`endif
            ADDR_PENDING:  rd_next = 32'(irq);
            default:       rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_next;
    end

endmodule

// File: tb/tb_system_acl_iface_pio_in.sv
// Bench for the debounced PIO input: register table, directed edge/irq/reset sequences,
// then random traffic against a cycle-level behavioural reference.
module tb_system_acl_iface_pio_in;

    localparam int W = 2;
`ifdef PIO_DEBOUNCE_EN
    localparam bit DBE = 1'b1;
`else
    localparam bit DBE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '0;
    logic         irq;

    system_acl_iface_pio_in_if bus ();

    system_acl_iface_pio_in #(.WIDTH(W), .DB_W(16), .DB_RST(16'd0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: input seen two samples late; a channel's level moves once the
    // synchronised input has disagreed with it for more than `limit` consecutive samples.
    logic [W-1:0] m_d0, m_d1, m_stable, m_prev, m_rise, m_fall, m_mask, m_cap;
    logic [W-1:0] m_edge, m_clr;
    int           m_run [W];
    int           m_lim;
    logic [31:0]  m_rd, m_rdn;
    logic         m_wr;
    logic         m_irq;
    assign m_irq = |(m_cap & m_mask);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_d0 = '0; m_d1 = '0; m_stable = '0; m_prev = '0;
            m_rise = '0; m_mask = '0; m_cap = '0; m_fall = '1;
            m_lim = 0; m_rd = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_wr = bus.chipselect && !bus.write_n;
            case (bus.address)
                3'd0:    m_rdn = 32'(m_stable);
                3'd1:    m_rdn = 32'(m_rise);
                3'd2:    m_rdn = 32'(m_mask);
                3'd3:    m_rdn = 32'(m_cap);
                3'd4:    m_rdn = 32'(m_fall);
                3'd5:    m_rdn = DBE ? 32'(m_lim) : 32'd0;
                3'd6:    m_rdn = 32'(m_irq);
                default: m_rdn = 32'd0;
            endcase
            m_edge = (m_stable & ~m_prev & m_rise) | (~m_stable & m_prev & m_fall);
            m_clr  = (m_wr && bus.address == 3'd3) ? bus.writedata[W-1:0] : '0;
            m_cap  = (m_cap & ~m_clr) | m_edge;
            m_prev = m_stable;
            for (int i = 0; i < W; i++) begin
                if (m_d1[i] == m_stable[i]) m_run[i] = 0;
                else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] > m_lim) begin
                        m_stable[i] = m_d1[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_d1 = m_d0;
            m_d0 = in_port;
            if (m_wr) begin
                case (bus.address)
                    3'd1: m_rise = bus.writedata[W-1:0];
                    3'd2: m_mask = bus.writedata[W-1:0];
                    3'd4: m_fall = bus.writedata[W-1:0];
                    3'd5: if (DBE) m_lim = int'(bus.writedata[15:0]);
                    default: ;
                endcase
            end
            m_rd = m_rdn;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("rnd_readdata", bus.readdata, m_rd);
            check("rnd_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(negedge clk);
        v = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(nm, v, exp);
    endtask

    typedef struct {
        logic        do_wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{1'b0, 3'd1, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 3'd4, 32'h0,         32'h3};
        tbl[2]  = '{1'b0, 3'd5, 32'h0,         32'h0};
        tbl[3]  = '{1'b0, 3'd6, 32'h0,         32'h0};
        tbl[4]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h3};
        tbl[5]  = '{1'b1, 3'd2, 32'hFFFF_FFFE, 32'h2};
        tbl[6]  = '{1'b1, 3'd4, 32'h0,         32'h0};
        tbl[7]  = '{1'b1, 3'd5, 32'h0001_1234, DBE ? 32'h1234 : 32'h0};
        tbl[8]  = '{1'b1, 3'd7, 32'hFFFF,      32'h0};
        tbl[9]  = '{1'b1, 3'd0, 32'h3,         32'h0};
        tbl[10] = '{1'b1, 3'd6, 32'h1,         32'h0};
        tbl[11] = '{1'b1, 3'd3, 32'h3,         32'h0};
        tbl[12] = '{1'b1, 3'd2, 32'h0,         32'h0};
        tbl[13] = '{1'b1, 3'd5, 32'h0,         32'h0};
        tbl[14] = '{1'b1, 3'd1, 32'h0,         32'h0};
        tbl[15] = '{1'b1, 3'd4, 32'hFFFF_FFFF, 32'h3};

        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        idle(3);
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            logic [31:0] v;
            if (tbl[i].do_wr) wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, v);
            if (v !== tbl[i].exp) $display("FAIL table[%0d] addr %0d: got %h want %h", i, tbl[i].addr, v, tbl[i].exp);
            n_cmp++;
            if (v !== tbl[i].exp) n_bad++;
        end

        // Falling edge on ch0 with zero debounce: captured on the 4th cycle.
        in_port = 2'b11;
        idle(6);
        wr(3'd3, 32'h3);
        wr(3'd2, 32'h1);
        in_port = 2'b10;
        idle(3);
        check("fall_irq_early", 32'(irq), 32'h0);
        idle(1);
        check("fall_irq", 32'(irq), 32'h1);
        rd_chk("fall_cap", 3'd3, 32'h1);
        rd_chk("fall_pending", 3'd6, 32'h1);

        // Rise-only capture on ch1.
        wr(3'd1, 32'h2); wr(3'd4, 32'h0); wr(3'd2, 32'h0);
        in_port = 2'b00;
        idle(6);
        wr(3'd3, 32'h3);
        in_port = 2'b10;
        idle(6);
        rd_chk("rise1_cap", 3'd3, 32'h2);
        in_port = 2'b00;
        idle(6);
        rd_chk("fall1_ignored", 3'd3, 32'h2);

        // Clear and a new edge on the same cycle: the edge wins.
        wr(3'd1, 32'h1); wr(3'd2, 32'h1); wr(3'd3, 32'h3);
        in_port = 2'b01;
        idle(6);
        check("rise0_irq", 32'(irq), 32'h1);
        in_port = 2'b00;
        idle(6);
        wr(3'd3, 32'h1);
        check("w1c_clears", 32'(irq), 32'h0);
        in_port = 2'b01;
        idle(3);
        bus.address = 3'd3; bus.writedata = 32'h1; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        check("set_wins_irq", 32'(irq), 32'h1);
        rd_chk("set_wins_cap", 3'd3, 32'h1);

`ifdef PIO_DEBOUNCE_EN
        // Short glitch is filtered, long hold is accepted.
        wr(3'd1, 32'h3); wr(3'd4, 32'h3); wr(3'd2, 32'h0); wr(3'd5, 32'd10);
        wr(3'd3, 32'h3);
        in_port = 2'b11;
        idle(5);
        in_port = 2'b01;
        idle(20);
        rd_chk("glitch_data", 3'd0, 32'h1);
        rd_chk("glitch_cap", 3'd3, 32'h0);
        in_port = 2'b11;
        idle(20);
        rd_chk("hold_data", 3'd0, 32'h3);
        rd_chk("hold_cap", 3'd3, 32'h2);
        wr(3'd2, 32'h3);
        check("pre_rst_irq", 32'(irq), 32'h1);
        in_port = 2'b00;
        idle(9);
`else
        wr(3'd2, 32'h3);
        in_port = 2'b00;
        idle(2);
`endif
        // Async reset mid-debounce.
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_rd", bus.readdata, 32'h0);
        check("rst_async_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_rd_next", bus.readdata, 32'h0);
        rd_chk("rst_rise", 3'd1, 32'h0);
        rd_chk("rst_mask", 3'd2, 32'h0);
        rd_chk("rst_cap", 3'd3, 32'h0);
        rd_chk("rst_fall", 3'd4, 32'h3);
        rd_chk("rst_dblim", 3'd5, 32'h0);
        rd_chk("rst_data", 3'd0, 32'h0);

        // Random traffic against the reference model.
        @(negedge clk);
        chk_en = 1'b1;
        for (int n = 0; n < 800; n++) begin
            int r;
            if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
            r = $urandom_range(0, 9);
            bus.address    = 3'($urandom_range(0, 7));
            bus.chipselect = ($urandom_range(0, 5) != 0);
            bus.write_n    = (r >= 3);
            bus.writedata  = (bus.address == 3'd5) ? 32'($urandom_range(0, 5)) : $urandom;
            if (bus.address == 3'd3 && $urandom_range(0, 2) != 0) bus.write_n = 1'b1;
            @(negedge clk);
        end
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/system_acl_iface_pio_in.md
SYSTEM_ACL_IFACE_PIO_IN -- requirements
Module: system_acl_iface_pio_in

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of input channels, legal 1..32.
REQ-002 SHALL have parameter DB_W, default 16: debounce counter width, legal 1..16.
REQ-003 SHALL have parameter DB_RST, default 16'd0: debounce limit value after reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port address, input, 3 bits: register select.
REQ-007 SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-009 SHALL have port writedata, input, 32 bits: write data.
REQ-010 SHALL have port in_port, input, WIDTH bits: asynchronous external inputs.
REQ-011 SHALL have port readdata, output, 32 bits: registered read data, zero-extended.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-013 SHALL apply the following register map (address: register, access): 0: DATA, RO, debounced level. 1: RISE_EN, RW. 2: IRQ_MASK, RW. 3: EDGE_CAP, write-1-to-clear. 4: FALL_EN, RW. 5: DB_LIMIT, RW, low DB_W bits. 6: PENDING, RO, bit0 = irq. 7: reads 0.
REQ-014 SHALL pass in_port through a 2-flop synchroniser per channel (sync).
REQ-015 SHALL keep, per channel, a stable level and a DB_W-bit counter: sync==stable -> counter cleared; otherwise counter increments; counter >= DB_LIMIT -> stable<=sync, counter cleared.
REQ-016 SHALL saturate the counter at all-ones and never wrap.
REQ-017 SHALL update stable one cycle after sync changes when DB_LIMIT==0.
REQ-018 SHALL apply a new DB_LIMIT on the cycle after the write; a counter already >= the new limit commits on that cycle.
REQ-019 SHALL detect a rise as stable 0->1 and a fall as stable 1->0; edge[i] = (rise&RISE_EN[i]) | (fall&FALL_EN[i]).
REQ-020 SHALL set EDGE_CAP[i] on edge[i]; writing 1 to bit i clears it; writing 0 leaves it unchanged.
REQ-021 SHALL give set priority when an edge and a clear of the same bit coincide, so EDGE_CAP[i] stays 1.
REQ-022 SHALL drive irq = |(EDGE_CAP & IRQ_MASK) combinationally from registers.
REQ-023 SHALL register readdata on every clock: one-cycle read latency, with no dependence on chipselect.
REQ-024 SHALL ignore writes to addresses 0, 6 and 7, and writedata bits above WIDTH (above DB_W for DB_LIMIT).

Reset
REQ-025 SHALL asynchronously reset on reset_n low: synchronisers, stable, counters, EDGE_CAP, IRQ_MASK, RISE_EN and readdata to 0; FALL_EN to all ones; DB_LIMIT to DB_RST; irq to 0.
REQ-026 SHALL produce no edge from the first post-reset transition unless stable actually changes from 0.
REQ-027 SHALL discard any debounce in progress when reset is asserted mid-count.

Configuration
REQ-028 SHALL, with PIO_DEBOUNCE_EN defined, include the REQ-015..018 counters and the DB_LIMIT register.
REQ-029 SHALL, without PIO_DEBOUNCE_EN, set stable = sync registered one more cycle; address 5 reads 0 and ignores writes.

Structure
REQ-030 SHALL place register address constants (ADDR_DATA..ADDR_PENDING) and the FALL_EN reset-value rule in shared package acl_pio_pkg.
REQ-031 SHALL implement the per-channel synchroniser and debounce as sub-module acl_pio_debounce, instantiated WIDTH times.

Verification
REQ-032 SHALL cover: WIDTH=2, DB_LIMIT=0, in_port 2'b11->2'b10 -> EDGE_CAP=2'b01 about 4 cycles later; with IRQ_MASK=1, irq=1.
REQ-033 SHALL cover: DB_LIMIT=10, a 5-cycle glitch on in_port[1] -> DATA unchanged, EDGE_CAP=0; a 20-cycle hold -> DATA[1] flips.
REQ-034 SHALL cover: RISE_EN=2'b10, FALL_EN=0, in_port[1] 0->1 -> EDGE_CAP=2'b10; the following 1->0 -> no new capture.
REQ-035 SHALL cover: write 1 to EDGE_CAP bit0 on the same cycle as a new edge on ch0 -> bit0 remains 1 and irq stays high.
REQ-036 SHALL cover: reset_n pulsed low mid-debounce (counter=7) -> all registers at reset values; readdata=0 next edge.
REQ-037 SHALL cover: build without PIO_DEBOUNCE_EN -> read of address 5 returns 0 after writing 0x1234.
